// File: rtl/aes_pkg.sv
// Shared types for the masked AES front-end: key sizes, the held request operands and the FSM states.
package aes_pkg;

   localparam int unsigned AES_BLOCK_W = 128;
   localparam int unsigned AES_KEY_W   = 256;

   typedef enum logic [1:0] {
      AES_128 = 2'b00,
      AES_192 = 2'b01,
      AES_256 = 2'b10
   } key_size_e;

   typedef struct packed {
      logic                   enc_dec;
      key_size_e              key_size;
      logic [AES_BLOCK_W-1:0] pt;
      logic [AES_BLOCK_W-1:0] pt_rand;
      logic [AES_KEY_W-1:0]   key;
      logic [AES_KEY_W-1:0]   key_rand;
   } aes_req_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT
   } fe_state_e;

endpackage

// File: rtl/aes_rsp_fifo.sv
// Synchronous response FIFO with an occupancy counter and wrapping pointers; no write-to-read bypass.
module aes_rsp_fifo #(
   parameter int unsigned WIDTH = 132,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             valid_o,
   output logic             full_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign valid_o = (count_q != '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign rdata_o = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      do_pop   = pop_i && valid_o;
      // A push into a full FIFO is only taken when the same cycle frees the head slot.
      do_push  = push_i && (!full_o || do_pop);
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata_i;
         wr_ptr_d        = inc_ptr(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = inc_ptr(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/aes_masked_frontend.sv
// Single-job request front-end for aes_masked_core: holds operands for the whole job, launches only
// with a guaranteed response slot, queues {tag, ct} results and zeroizes secrets after each job.
module aes_masked_frontend
   import aes_pkg::*;
#(
   parameter int unsigned TAG_W     = 4,
   parameter int unsigned RSP_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_enc_dec_i,
   input  key_size_e         req_key_size_i,
   input  logic [TAG_W-1:0]  req_tag_i,
   input  logic [127:0]      req_pt_i,
   input  logic [127:0]      req_pt_rand_i,
   input  logic [255:0]      req_key_i,
   input  logic [255:0]      req_key_rand_i,
   output logic              core_start_o,
   output logic              core_enc_dec_o,
   output key_size_e         core_key_size_o,
   output logic [127:0]      core_pt_o,
   output logic [127:0]      core_pt_rand_o,
   output logic [255:0]      core_key_o,
   output logic [255:0]      core_key_rand_o,
   input  logic              core_busy_i,
   input  logic              core_done_i,
   input  logic [127:0]      core_ct_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [TAG_W-1:0]  rsp_tag_o,
   output logic [127:0]      rsp_data_o,
   output logic              err_o
);

   localparam int unsigned RSP_W = TAG_W + AES_BLOCK_W;

   fe_state_e        state_q, state_d;
   aes_req_t         hold_q, hold_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             start_q, start_d;
   logic             err_q, err_d;
   logic             fifo_push, fifo_full;
   logic [RSP_W-1:0] fifo_rdata;

   assign req_ready_o     = (state_q == S_IDLE);
   assign core_start_o    = start_q;
   assign core_enc_dec_o  = hold_q.enc_dec;
   assign core_key_size_o = hold_q.key_size;
   assign core_pt_o       = hold_q.pt;
   assign core_pt_rand_o  = hold_q.pt_rand;
   assign core_key_o      = hold_q.key;
   assign core_key_rand_o = hold_q.key_rand;
   assign err_o           = err_q;
   assign rsp_tag_o       = fifo_rdata[RSP_W-1 -: TAG_W];
   assign rsp_data_o      = fifo_rdata[AES_BLOCK_W-1:0];

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      tag_d     = tag_q;
      start_d   = 1'b0;
      err_d     = err_q;
      fifo_push = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               hold_d.enc_dec  = req_enc_dec_i;
               hold_d.key_size = req_key_size_i;
               hold_d.pt       = req_pt_i;
               hold_d.pt_rand  = req_pt_rand_i;
               hold_d.key      = req_key_i;
               hold_d.key_rand = req_key_rand_i;
               tag_d           = req_tag_i;
               state_d         = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            // Launching only with a free FIFO slot means the eventual push can never be refused.
            if (!core_busy_i && !fifo_full) begin
               start_d = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (core_done_i) begin
               fifo_push       = 1'b1;
               hold_d.pt       = '0;
               hold_d.pt_rand  = '0;
               hold_d.key      = '0;
               hold_d.key_rand = '0;
               state_d         = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (core_done_i && (state_q != S_WAIT)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         hold_q  <= '0;
         tag_q   <= '0;
         start_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         tag_q   <= tag_d;
         start_q <= start_d;
         err_q   <= err_d;
      end
   end

   aes_rsp_fifo #(
      .WIDTH (RSP_W),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push),
      .wdata_i ({tag_q, core_ct_i}),
      .pop_i   (rsp_ready_i),
      .rdata_o (fifo_rdata),
      .valid_o (rsp_valid_o),
      .full_o  (fifo_full)
   );

endmodule

// File: tb/tb_aes_masked_frontend.sv
// Scoreboard bench for aes_masked_frontend with a behavioural core stand-in that also polices operand stability.
module tb_aes_masked_frontend;
   import aes_pkg::*;

   localparam int TAG_W     = 4;
   localparam int RSP_DEPTH = 2;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req_valid_i;
   logic             req_ready_o;
   logic             req_enc_dec_i;
   key_size_e        req_key_size_i;
   logic [TAG_W-1:0] req_tag_i;
   logic [127:0]     req_pt_i, req_pt_rand_i;
   logic [255:0]     req_key_i, req_key_rand_i;
   logic             core_start_o, core_enc_dec_o;
   key_size_e        core_key_size_o;
   logic [127:0]     core_pt_o, core_pt_rand_o;
   logic [255:0]     core_key_o, core_key_rand_o;
   logic             core_busy_i, core_done_i, model_done, inject_done;
   logic [127:0]     core_ct_i;
   logic             rsp_valid_o, rsp_ready_i;
   logic [TAG_W-1:0] rsp_tag_o;
   logic [127:0]     rsp_data_o;
   logic             err_o;

   int checks = 0;
   int errors = 0;
   int starts = 0;
   bit active = 1'b0;
   int ready_mode = 1;
   logic [TAG_W+127:0] exp_q [$];

   assign core_done_i = model_done | inject_done;

   always #5 clk = ~clk;

   aes_masked_frontend #(.TAG_W(TAG_W), .RSP_DEPTH(RSP_DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_enc_dec_i(req_enc_dec_i), .req_key_size_i(req_key_size_i), .req_tag_i(req_tag_i),
      .req_pt_i(req_pt_i), .req_pt_rand_i(req_pt_rand_i),
      .req_key_i(req_key_i), .req_key_rand_i(req_key_rand_i),
      .core_start_o(core_start_o), .core_enc_dec_o(core_enc_dec_o), .core_key_size_o(core_key_size_o),
      .core_pt_o(core_pt_o), .core_pt_rand_o(core_pt_rand_o),
      .core_key_o(core_key_o), .core_key_rand_o(core_key_rand_o),
      .core_busy_i(core_busy_i), .core_done_i(core_done_i), .core_ct_i(core_ct_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_tag_o(rsp_tag_o), .rsp_data_o(rsp_data_o), .err_o(err_o)
   );

   // Stand-in cipher: the two FIPS-197 vectors exactly, otherwise an arbitrary key/mode-dependent mix.
   function automatic logic [127:0] ref_aes(input logic enc, input key_size_e ks,
                                            input logic [127:0] pt, input logic [255:0] key);
      logic [1:0] k;
      k = ks;
      if (!enc && ks == AES_128 && key == {C1_KEY, 128'h0} && pt == C1_PT) return C1_CT;
      if (enc && ks == AES_256 && key == C3_KEY && pt == C3_CT) return C1_PT;
      return pt ^ key[255:128] ^ {key[63:0], key[127:64]} ^ {32{k, enc, 1'b1}};
   endfunction

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic enc, input key_size_e ks, input logic [TAG_W-1:0] tag,
                                input logic [127:0] pt, input logic [127:0] ptr,
                                input logic [255:0] key, input logic [255:0] keyr);
      int n;
      @(negedge clk);
      req_enc_dec_i  = enc;
      req_key_size_i = ks;
      req_tag_i      = tag;
      req_pt_i       = pt;
      req_pt_rand_i  = ptr;
      req_key_i      = key;
      req_key_rand_i = keyr;
      req_valid_i    = 1'b1;
      n = 0;
      while (!req_ready_o && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready_o) begin
         checkOutput("accept_timeout", 256'(req_ready_o), 256'd1);
         req_valid_i = 1'b0;
         return;
      end
      exp_q.push_back({tag, ref_aes(enc, ks, pt, key)});
      @(negedge clk);
      req_valid_i = 1'b0;
      checkOutput("ready_low_after_accept", 256'(req_ready_o), 256'd0);
   endtask

   task automatic waitDrain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || active) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain", 256'(exp_q.size()), 256'd0);
   endtask

   task automatic applyReset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      exp_q.delete();
      @(negedge clk);
      checkOutput("rst_req_ready", 256'(req_ready_o), 256'd1);
      checkOutput("rst_rsp_valid", 256'(rsp_valid_o), 256'd0);
      checkOutput("rst_core_start", 256'(core_start_o), 256'd0);
      checkOutput("rst_err", 256'(err_o), 256'd0);
      checkOutput("rst_core_key", core_key_o, 256'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   // Behavioural core: busy for a random number of cycles after start, then a one-cycle done.
   initial begin
      logic         s_enc;
      key_size_e    s_ks;
      logic [127:0] s_pt, s_ptr;
      logic [255:0] s_key, s_keyr;
      int           left;
      model_done  = 1'b0;
      core_busy_i = 1'b0;
      core_ct_i   = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            active      = 1'b0;
            model_done  = 1'b0;
            core_busy_i = 1'b0;
            continue;
         end
         if (model_done) begin
            model_done = 1'b0;
            checkOutput("zeroize_key", core_key_o, 256'd0);
            checkOutput("zeroize_key_rand", core_key_rand_o, 256'd0);
            checkOutput("zeroize_pt", 256'(core_pt_o), 256'd0);
            checkOutput("zeroize_pt_rand", 256'(core_pt_rand_o), 256'd0);
            checkOutput("hold_mode", 256'({core_enc_dec_o, core_key_size_o}), 256'({s_enc, s_ks}));
         end
         if (active) begin
            checkOutput("start_single_cycle", 256'(core_start_o), 256'd0);
            checkOutput("ready_low_wait", 256'(req_ready_o), 256'd0);
            checkOutput("stable_mode", 256'({core_enc_dec_o, core_key_size_o}), 256'({s_enc, s_ks}));
            checkOutput("stable_pt", 256'(core_pt_o), 256'(s_pt));
            checkOutput("stable_pt_rand", 256'(core_pt_rand_o), 256'(s_ptr));
            checkOutput("stable_key", core_key_o, s_key);
            checkOutput("stable_key_rand", core_key_rand_o, s_keyr);
            left--;
            if (left == 0) begin
               core_ct_i   = ref_aes(core_enc_dec_o, core_key_size_o, core_pt_o, core_key_o);
               model_done  = 1'b1;
               core_busy_i = 1'b0;
               active      = 1'b0;
            end
         end else if (core_start_o) begin
            s_enc  = core_enc_dec_o;
            s_ks   = core_key_size_o;
            s_pt   = core_pt_o;
            s_ptr  = core_pt_rand_o;
            s_key  = core_key_o;
            s_keyr = core_key_rand_o;
            active      = 1'b1;
            core_busy_i = 1'b1;
            left        = $urandom_range(2, 6);
            starts++;
         end
      end
   end

   // Downstream ready: 0 = stall, 1 = always, 2 = random, 3 = single-cycle pulse.
   initial begin
      rsp_ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0: rsp_ready_i = 1'b0;
            1: rsp_ready_i = 1'b1;
            3: begin
               rsp_ready_i = 1'b1;
               ready_mode  = 0;
            end
            default: rsp_ready_i = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Response monitor: every accepted response must match the oldest expected entry.
   initial begin
      logic [TAG_W+127:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
               checkOutput("rsp_unexpected", 256'({rsp_tag_o, rsp_data_o}), 256'd0);
            end else begin
               e = exp_q.pop_front();
               checkOutput("rsp_tag", 256'(rsp_tag_o), 256'(e[TAG_W+127:128]));
               checkOutput("rsp_data", 256'(rsp_data_o), 256'(e[127:0]));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int s0;
      rst_n          = 1'b0;
      req_valid_i    = 1'b0;
      inject_done    = 1'b0;
      req_enc_dec_i  = 1'b0;
      req_key_size_i = AES_128;
      req_tag_i      = '0;
      req_pt_i       = '0;
      req_pt_rand_i  = '0;
      req_key_i      = '0;
      req_key_rand_i = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset_req_ready", 256'(req_ready_o), 256'd1);
      checkOutput("reset_core_start", 256'(core_start_o), 256'd0);
      checkOutput("reset_rsp_valid", 256'(rsp_valid_o), 256'd0);
      checkOutput("reset_err", 256'(err_o), 256'd0);
      checkOutput("reset_core_key", core_key_o, 256'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      $display("[TB] FIPS-197 vectors");
      applyStimulus(1'b0, AES_128, 4'd3, C1_PT, 128'($urandom), {C1_KEY, 128'h0},
                    {8{32'($urandom)}});
      waitDrain(200);
      applyStimulus(1'b1, AES_256, 4'd5, C3_CT, 128'($urandom), C3_KEY, {8{32'($urandom)}});
      waitDrain(200);
      checkOutput("err_clear_normal", 256'(err_o), 256'd0);

      $display("[TB] random jobs with random backpressure");
      ready_mode = 2;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'($urandom), key_size_e'($urandom_range(0, 2)), 4'($urandom),
                       {$urandom, $urandom, $urandom, $urandom},
                       {$urandom, $urandom, $urandom, $urandom},
                       {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                       {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      end
      ready_mode = 1;
      waitDrain(2000);

      $display("[TB] full response FIFO stalls launch");
      ready_mode = 0;
      @(negedge clk);
      s0 = starts;
      for (int i = 0; i < RSP_DEPTH + 1; i++) begin
         applyStimulus(1'b0, AES_192, 4'(8 + i), {4{$urandom}}, {4{$urandom}},
                       {8{$urandom}}, {8{$urandom}});
      end
      repeat (30) @(negedge clk);
      checkOutput("starts_while_full", 256'(starts - s0), 256'(RSP_DEPTH));
      checkOutput("ready_low_stalled", 256'(req_ready_o), 256'd0);
      checkOutput("rsp_valid_full", 256'(rsp_valid_o), 256'd1);
      ready_mode = 3;
      repeat (30) @(negedge clk);
      checkOutput("starts_after_pop", 256'(starts - s0), 256'(RSP_DEPTH + 1));
      ready_mode = 1;
      waitDrain(500);

      $display("[TB] stray done while idle");
      @(negedge clk);
      inject_done = 1'b1;
      @(negedge clk);
      inject_done = 1'b0;
      checkOutput("err_set", 256'(err_o), 256'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("no_rsp_after_stray", 256'(rsp_valid_o), 256'd0);
      end
      applyStimulus(1'b0, AES_256, 4'd7, {4{$urandom}}, {4{$urandom}}, {8{$urandom}}, {8{$urandom}});
      waitDrain(200);
      checkOutput("err_sticky", 256'(err_o), 256'd1);

      $display("[TB] reset during job");
      applyStimulus(1'b1, AES_128, 4'd9, {4{$urandom}}, {4{$urandom}}, {8{$urandom}}, {8{$urandom}});
      begin
         int n;
         n = 0;
         while (!active && n < 100) begin
            @(negedge clk);
            n++;
         end
         checkOutput("job_in_flight", 256'(active), 256'd1);
      end
      applyReset();
      applyStimulus(1'b0, AES_128, 4'd3, C1_PT, 128'($urandom), {C1_KEY, 128'h0}, {8{$urandom}});
      waitDrain(200);

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
